// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] PC_STEP = 32'd4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {BOOT, REQ, DROP} fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response handshake between fetch (master) and memory (slave).
interface fetch_stage_if;
  import fetch_pkg::*;

  logic              req;
  logic [INST_W-1:0] addr;
  logic              ready;
  logic [INST_W-1:0] rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave (input req, addr, output ready, rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction returned while decode is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              pop,
  input  logic              clear,
  input  logic [INST_W-1:0] wr_inst,
  input  logic [INST_W-1:0] wr_pc,
  output logic              full,
  output logic [INST_W-1:0] rd_inst,
  output logic [INST_W-1:0] rd_pc
);

  logic              full_q;
  logic [INST_W-1:0] inst_q;
  logic [INST_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full_q <= 1'b0;
    end else if (load) begin
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while full_q is set.
  always_ff @(posedge clk) begin
    if (load) begin
      inst_q <= wr_inst;
      pc_q   <= wr_pc;
    end
  end

  assign full    = full_q;
  assign rd_inst = inst_q;
  assign rd_pc   = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register and stall skid buffer.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped event counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_d,
  input  logic                  branch_taken_d,
  input  logic [31:0]           branch_target_d,
  fetch_stage_if.master         imem,
  output logic [31:0]           inst_d,
  output logic [31:0]           pc_d,
  output logic [31:0]           pc_plus4_d,
`ifdef FETCH_PERF_EN
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_dropped,
`endif
  output logic                  valid_d
);
  import fetch_pkg::*;

  fetch_state_t      st_q, st_d;
  logic [INST_W-1:0] pc_f_q, pc_f_d;
  logic [INST_W-1:0] tgt_q, tgt_d;
  logic [INST_W-1:0] ifid_inst_q, ifid_inst_d;
  logic [INST_W-1:0] ifid_pc_q, ifid_pc_d;
  logic              ifid_valid_q, ifid_valid_d;

  logic              skid_full, skid_load, skid_pop;
  logic [INST_W-1:0] skid_inst, skid_pc;
  logic [INST_W-1:0] target;
  logic              done, fetch_ok, ifid_fill;

  assign target = {branch_target_d[31:2], 2'b00};

  always_comb begin
    st_d         = st_q;
    pc_f_d       = pc_f_q;
    tgt_d        = tgt_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    skid_load    = 1'b0;
    skid_pop     = 1'b0;
    ifid_fill    = 1'b0;

    // A full skid blocks new requests until decode drains it.
    imem.req = ((st_q == REQ) && !skid_full) || (st_q == DROP);
    done     = imem.req && imem.ready;
    fetch_ok = done && (st_q == REQ);

    case (st_q)
      BOOT: begin
        st_d = REQ;
        if (branch_taken_d) pc_f_d = target;
      end
      REQ: begin
        if (branch_taken_d) begin
          if (done) begin
            pc_f_d = target;
          end else if (imem.req) begin
            tgt_d = target;
            st_d  = DROP;
          end else begin
            pc_f_d = target;
          end
        end else if (done) begin
          pc_f_d = pc_f_q + PC_STEP;
        end
      end
      DROP: begin
        if (done) begin
          st_d   = REQ;
          pc_f_d = branch_taken_d ? target : tgt_q;
        end else if (branch_taken_d) begin
          tgt_d = target;
        end
      end
      default: st_d = BOOT;
    endcase

    if (branch_taken_d) begin
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
    end else if (stall_d) begin
      skid_load = fetch_ok;
    end else if (skid_full) begin
      skid_pop     = 1'b1;
      ifid_fill    = 1'b1;
      ifid_inst_d  = skid_inst;
      ifid_pc_d    = skid_pc;
      ifid_valid_d = 1'b1;
    end else if (fetch_ok) begin
      ifid_fill    = 1'b1;
      ifid_inst_d  = imem.rdata;
      ifid_pc_d    = pc_f_q;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= BOOT;
      pc_f_q       <= RESET_PC;
      tgt_q        <= '0;
      ifid_inst_q  <= NOP_INST;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      pc_f_q       <= pc_f_d;
      tgt_q        <= tgt_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .pop     (skid_pop),
    .clear   (branch_taken_d),
    .wr_inst (imem.rdata),
    .wr_pc   (pc_f_q),
    .full    (skid_full),
    .rd_inst (skid_inst),
    .rd_pc   (skid_pc)
  );

  assign imem.addr  = pc_f_q;
  assign inst_d     = ifid_inst_q;
  assign pc_d       = ifid_pc_q;
  assign pc_plus4_d = ifid_pc_q + PC_STEP;
  assign valid_d    = ifid_valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, dropped_q;
  logic [31:0] drop_inc;

  // Discarded response, flushed IF/ID entry and cleared skid entry can coincide.
  assign drop_inc = {31'd0, done && (branch_taken_d || (st_q == DROP))}
                  + {31'd0, branch_taken_d && ifid_valid_q}
                  + {31'd0, branch_taken_d && skid_full};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      fetched_q <= fetched_q + {31'd0, ifid_fill};
      dropped_q <= dropped_q + drop_inc;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_dropped = dropped_q;
`endif

endmodule
